fifo_ctrl_4x8: RTL and testbench

FIFO controller that drives the 4x8 dual-port memory as its write/read initiator, in place of the stimulus tester. It accepts push/pop requests from upstream and downstream logic, generates `write`, `read`, `wr_ptr`, `rd_ptr` and `data_in` toward the memory, and returns `data_out` with a valid strobe. It also tracks occupancy and status flags, and forms the buffering stage of each switch lane.

---
 rtl/fifo_ctrl_4x8_if.sv | 39 +++
 rtl/fifo_ctrl_4x8.sv | 169 ++++++++++++++++
 tb/tb_fifo_ctrl_4x8.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_4x8_if.sv
// +-----------------------------------------------------------------------+
// | Module   : fifo_ctrl_4x8_if                                           |
// | Brief    : Memory-side bus between the FIFO controller and the 4x8    |
// |            dual-port memory (controller = master, memory = slave).    |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

interface fifo_ctrl_4x8_if #(
  parameter int MAIN_SIZE = 4,
  parameter int DATA_SIZE = 8
);
  logic                 write;
  logic                 read;
  logic [MAIN_SIZE-1:0] wr_ptr;
  logic [MAIN_SIZE-1:0] rd_ptr;
  logic [DATA_SIZE-1:0] data_in;
  logic [DATA_SIZE-1:0] data_out;

  modport master (
    output write,
    output read,
    output wr_ptr,
    output rd_ptr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  write,
    input  read,
    input  wr_ptr,
    input  rd_ptr,
    input  data_in,
    output data_out
  );
endinterface

`default_nettype wire

// File: rtl/fifo_ctrl_4x8.sv
// +-----------------------------------------------------------------------+
// | Module   : fifo_ctrl_4x8                                              |
// | Brief    : FIFO controller acting as write/read initiator for the     |
// |            4x8 dual-port memory; tracks occupancy and status flags.   |
// |            Optional sticky error flag built when FIFO_ERR_EN is       |
// |            defined, otherwise err is tied low.                        |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

module fifo_ctrl_4x8 #(
  parameter int MAIN_SIZE = 4,
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 push,
  input  wire logic                 pop,
  input  wire logic [DATA_SIZE-1:0] fifo_data_in,
  output logic      [DATA_SIZE-1:0] fifo_data_out,
  output logic                      fifo_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic      [MAIN_SIZE:0]   count,
  output logic                      err,
  fifo_ctrl_4x8_if.master           mem_if
);

  localparam logic [MAIN_SIZE-1:0] C_LAST_IDX = MAIN_SIZE'(DEPTH - 1);
  localparam logic [MAIN_SIZE-1:0] C_IDX_ONE  = MAIN_SIZE'(1);
  localparam logic [MAIN_SIZE:0]   C_DEPTH    = (MAIN_SIZE + 1)'(DEPTH);
  localparam logic [MAIN_SIZE:0]   C_AF       = (MAIN_SIZE + 1)'(AF_THRESH);
  localparam logic [MAIN_SIZE:0]   C_AE       = (MAIN_SIZE + 1)'(AE_THRESH);
  localparam logic [MAIN_SIZE:0]   C_CNT_ONE  = (MAIN_SIZE + 1)'(1);

  logic [MAIN_SIZE-1:0] wr_idx_q,        wr_idx_d;
  logic [MAIN_SIZE-1:0] rd_idx_q,        rd_idx_d;
  logic [MAIN_SIZE:0]   count_q,         count_d;
  logic                 write_q,         write_d;
  logic                 read_q,          read_d;
  logic [MAIN_SIZE-1:0] wr_ptr_q,        wr_ptr_d;
  logic [MAIN_SIZE-1:0] rd_ptr_q,        rd_ptr_d;
  logic [DATA_SIZE-1:0] data_in_q,       data_in_d;
  logic                 rd_v1_q,         rd_v1_d;
  logic                 fifo_valid_q,    fifo_valid_d;
  logic [DATA_SIZE-1:0] fifo_data_out_q, fifo_data_out_d;

  logic push_ok;
  logic pop_ok;

  function automatic logic [MAIN_SIZE-1:0] next_idx(input logic [MAIN_SIZE-1:0] idx);
    return (idx == C_LAST_IDX) ? '0 : idx + C_IDX_ONE;
  endfunction

  // Flags decode straight from the registered count so they clear with reset.
  assign full         = (count_q == C_DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= C_AF);
  assign almost_empty = (count_q <= C_AE);

  // A pop on empty is never accepted, so a full FIFO is the only case where
  // a same-cycle pop can make room for a push.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_idx_d        = wr_idx_q;
    rd_idx_d        = rd_idx_q;
    count_d         = count_q;
    write_d         = push_ok;
    read_d          = pop_ok;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    data_in_d       = data_in_q;
    rd_v1_d         = read_q;
    fifo_valid_d    = rd_v1_q;
    fifo_data_out_d = fifo_data_out_q;

    if (push_ok) begin
      wr_ptr_d  = wr_idx_q;
      data_in_d = fifo_data_in;
      wr_idx_d  = next_idx(wr_idx_q);
    end

    if (pop_ok) begin
      rd_ptr_d = rd_idx_q;
      rd_idx_d = next_idx(rd_idx_q);
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase

    // Memory registered its read one edge ago; capture it now.
    if (rd_v1_q) begin
      fifo_data_out_d = mem_if.data_out;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx_q        <= '0;
      rd_idx_q        <= '0;
      count_q         <= '0;
      write_q         <= 1'b0;
      read_q          <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      data_in_q       <= '0;
      rd_v1_q         <= 1'b0;
      fifo_valid_q    <= 1'b0;
      fifo_data_out_q <= '0;
    end else begin
      wr_idx_q        <= wr_idx_d;
      rd_idx_q        <= rd_idx_d;
      count_q         <= count_d;
      write_q         <= write_d;
      read_q          <= read_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      data_in_q       <= data_in_d;
      rd_v1_q         <= rd_v1_d;
      fifo_valid_q    <= fifo_valid_d;
      fifo_data_out_q <= fifo_data_out_d;
    end
  end

`ifdef FIFO_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((push && full && !pop_ok) || (pop && empty)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign count          = count_q;
  assign fifo_valid     = fifo_valid_q;
  assign fifo_data_out  = fifo_data_out_q;
  assign mem_if.write   = write_q;
  assign mem_if.read    = read_q;
  assign mem_if.wr_ptr  = wr_ptr_q;
  assign mem_if.rd_ptr  = rd_ptr_q;
  assign mem_if.data_in = data_in_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl_4x8.sv
// +-----------------------------------------------------------------------+
// | Module   : tb_fifo_ctrl_4x8                                           |
// | Brief    : Self-checking bench for fifo_ctrl_4x8 with a behavioural   |
// |            4x8 memory, vector table and output scoreboard.            |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_fifo_ctrl_4x8;

`ifdef FIFO_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] fifo_data_in = 8'h00;
  logic [7:0] fifo_data_out;
  logic       fifo_valid;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       err;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  fifo_ctrl_4x8_if #(.MAIN_SIZE(4), .DATA_SIZE(8)) mif ();

  fifo_ctrl_4x8 #(
    .MAIN_SIZE(4), .DATA_SIZE(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .push          (push),
    .pop           (pop),
    .fifo_data_in  (fifo_data_in),
    .fifo_data_out (fifo_data_out),
    .fifo_valid    (fifo_valid),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .count         (count),
    .err           (err),
    .mem_if        (mif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 4x8 memory: write stores, read registers the old contents.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (mif.write) mem[mif.wr_ptr] <= mif.data_in;
    if (mif.read)  mif.data_out <= mem[mif.rd_ptr];
  end

  typedef struct {
    logic [1:0] pp;     // {push, pop}
    logic [7:0] din;
    logic [4:0] cnt;
    logic [3:0] flg;    // {full, empty, almost_full, almost_empty}
    logic [1:0] wr_rd;  // {write, read}
    logic [3:0] wp;
    logic [7:0] di;
    logic [3:0] rp;
    logic       e;      // err value when the error logic is built
  } vec_t;

  typedef struct {
    logic [7:0] d;
    int         due;
  } sb_t;

  vec_t       vt [26];
  sb_t        sb [$];
  logic [7:0] mq [$];

  function automatic vec_t mk(input logic [1:0] pp, input logic [7:0] din,
                              input logic [4:0] cnt, input logic [3:0] flg,
                              input logic [1:0] wr_rd, input logic [3:0] wp,
                              input logic [7:0] di, input logic [3:0] rp,
                              input logic e);
    vec_t v;
    v.pp = pp; v.din = din; v.cnt = cnt; v.flg = flg; v.wr_rd = wr_rd;
    v.wp = wp; v.di = di; v.rp = rp; v.e = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic apply(input logic p, input logic q, input logic [7:0] d);
    @(negedge clk);
    push = p; pop = q; fifo_data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_add(input logic [7:0] d);
    sb_t ent;
    ent.d   = d;
    ent.due = cyc + 2;
    sb.push_back(ent);
  endtask

  // Output monitor: every fifo_valid must match the oldest expected pop.
  always begin : mon
    sb_t e;
    @(posedge clk);
    #1;
    if (fifo_valid) begin
      n_run++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got fifo_valid=1 data %0h, expected no output", fifo_data_out);
      end else begin
        e = sb.pop_front();
        if (fifo_data_out !== e.d || cyc != e.due) begin
          n_fail++;
          $display("FAIL pop_data: got %0h at cycle %0d, expected %0h at cycle %0d",
                   fifo_data_out, cyc, e.d, e.due);
        end
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      n_run++;
      n_fail++;
      $display("FAIL missing_valid: got no fifo_valid by cycle %0d, expected %0h", cyc, sb[0].d);
      void'(sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    //          pp     din    cnt    flg      wr_rd  wp     di     rp     e
    vt[0]  = mk(2'b10, 8'hFF, 5'd1, 4'b0001, 2'b10, 4'd0, 8'hFF, 4'd0, 1'b0);
    vt[1]  = mk(2'b10, 8'hDD, 5'd2, 4'b0000, 2'b10, 4'd1, 8'hDD, 4'd0, 1'b0);
    vt[2]  = mk(2'b10, 8'hEE, 5'd3, 4'b0010, 2'b10, 4'd2, 8'hEE, 4'd0, 1'b0);
    vt[3]  = mk(2'b10, 8'hCC, 5'd4, 4'b1010, 2'b10, 4'd3, 8'hCC, 4'd0, 1'b0);
    vt[4]  = mk(2'b10, 8'hBB, 5'd4, 4'b1010, 2'b00, 4'd3, 8'hCC, 4'd0, 1'b1);
    vt[5]  = mk(2'b01, 8'h00, 5'd3, 4'b0010, 2'b01, 4'd3, 8'hCC, 4'd0, 1'b1);
    vt[6]  = mk(2'b01, 8'h00, 5'd2, 4'b0000, 2'b01, 4'd3, 8'hCC, 4'd1, 1'b1);
    vt[7]  = mk(2'b01, 8'h00, 5'd1, 4'b0001, 2'b01, 4'd3, 8'hCC, 4'd2, 1'b1);
    vt[8]  = mk(2'b01, 8'h00, 5'd0, 4'b0101, 2'b01, 4'd3, 8'hCC, 4'd3, 1'b1);
    vt[9]  = mk(2'b01, 8'h00, 5'd0, 4'b0101, 2'b00, 4'd3, 8'hCC, 4'd3, 1'b1);
    vt[10] = mk(2'b00, 8'h00, 5'd0, 4'b0101, 2'b00, 4'd3, 8'hCC, 4'd3, 1'b1);
    vt[11] = mk(2'b10, 8'h11, 5'd1, 4'b0001, 2'b10, 4'd0, 8'h11, 4'd3, 1'b1);
    vt[12] = mk(2'b10, 8'h22, 5'd2, 4'b0000, 2'b10, 4'd1, 8'h22, 4'd3, 1'b1);
    vt[13] = mk(2'b11, 8'h33, 5'd2, 4'b0000, 2'b11, 4'd2, 8'h33, 4'd0, 1'b1);
    vt[14] = mk(2'b11, 8'h44, 5'd2, 4'b0000, 2'b11, 4'd3, 8'h44, 4'd1, 1'b1);
    vt[15] = mk(2'b11, 8'h55, 5'd2, 4'b0000, 2'b11, 4'd0, 8'h55, 4'd2, 1'b1);
    vt[16] = mk(2'b11, 8'h66, 5'd2, 4'b0000, 2'b11, 4'd1, 8'h66, 4'd3, 1'b1);
    vt[17] = mk(2'b01, 8'h00, 5'd1, 4'b0001, 2'b01, 4'd1, 8'h66, 4'd0, 1'b1);
    vt[18] = mk(2'b01, 8'h00, 5'd0, 4'b0101, 2'b01, 4'd1, 8'h66, 4'd1, 1'b1);
    vt[19] = mk(2'b10, 8'hA1, 5'd1, 4'b0001, 2'b10, 4'd2, 8'hA1, 4'd1, 1'b1);
    vt[20] = mk(2'b10, 8'hA2, 5'd2, 4'b0000, 2'b10, 4'd3, 8'hA2, 4'd1, 1'b1);
    vt[21] = mk(2'b10, 8'hA3, 5'd3, 4'b0010, 2'b10, 4'd0, 8'hA3, 4'd1, 1'b1);
    vt[22] = mk(2'b10, 8'hA4, 5'd4, 4'b1010, 2'b10, 4'd1, 8'hA4, 4'd1, 1'b1);
    vt[23] = mk(2'b11, 8'hA5, 5'd4, 4'b1010, 2'b11, 4'd2, 8'hA5, 4'd2, 1'b1);
    vt[24] = mk(2'b00, 8'h00, 5'd4, 4'b1010, 2'b00, 4'd2, 8'hA5, 4'd2, 1'b1);
    vt[25] = mk(2'b00, 8'h00, 5'd4, 4'b1010, 2'b00, 4'd2, 8'hA5, 4'd2, 1'b1);

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst.count", 32'(count), 32'd0);
      chk("rst.empty", 32'(empty), 32'd1);
      chk("rst.almost_empty", 32'(almost_empty), 32'd1);
      chk("rst.write", 32'(mif.write), 32'd0);
      chk("rst.read", 32'(mif.read), 32'd0);
      chk("rst.fifo_valid", 32'(fifo_valid), 32'd0);
      chk("rst.err", 32'(err), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      apply(vt[i].pp[1], vt[i].pp[0], vt[i].din);
      chk($sformatf("v%0d.count", i), 32'(count), 32'(vt[i].cnt));
      chk($sformatf("v%0d.flags", i), 32'({full, empty, almost_full, almost_empty}), 32'(vt[i].flg));
      chk($sformatf("v%0d.wr_rd", i), 32'({mif.write, mif.read}), 32'(vt[i].wr_rd));
      chk($sformatf("v%0d.wr_ptr", i), 32'(mif.wr_ptr), 32'(vt[i].wp));
      chk($sformatf("v%0d.data_in", i), 32'(mif.data_in), 32'(vt[i].di));
      chk($sformatf("v%0d.rd_ptr", i), 32'(mif.rd_ptr), 32'(vt[i].rp));
      chk($sformatf("v%0d.err", i), 32'(err), 32'(vt[i].e & ERR_ON));
      if (vt[i].wr_rd[1]) mq.push_back(vt[i].din);
      if (vt[i].wr_rd[0] && mq.size() > 0) sb_add(mq.pop_front());
    end

    // Pop, then reset mid-cycle before the read data can emerge
    apply(1'b0, 1'b1, 8'h00);
    chk("mid.read", 32'(mif.read), 32'd1);
    chk("mid.rd_ptr", 32'(mif.rd_ptr), 32'd3);
    chk("mid.count", 32'(count), 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    pop = 1'b0;
    #1;
    chk("mid_rst.count", 32'(count), 32'd0);
    chk("mid_rst.empty", 32'(empty), 32'd1);
    chk("mid_rst.almost_empty", 32'(almost_empty), 32'd1);
    chk("mid_rst.wr_ptr", 32'(mif.wr_ptr), 32'd0);
    chk("mid_rst.rd_ptr", 32'(mif.rd_ptr), 32'd0);
    chk("mid_rst.read", 32'(mif.read), 32'd0);
    chk("mid_rst.data_out", 32'(fifo_data_out), 32'd0);
    chk("mid_rst.err", 32'(err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("mid_rst.fifo_valid", 32'(fifo_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();

    // Push with pop on empty: push taken, pop refused
    apply(1'b1, 1'b1, 8'h5A);
    chk("pe.count", 32'(count), 32'd1);
    chk("pe.wr_rd", 32'({mif.write, mif.read}), 32'b10);
    chk("pe.wr_ptr", 32'(mif.wr_ptr), 32'd0);
    chk("pe.data_in", 32'(mif.data_in), 32'h5A);
    chk("pe.err", 32'(err), 32'(ERR_ON));
    apply(1'b0, 1'b1, 8'h00);
    chk("pe_pop.read", 32'(mif.read), 32'd1);
    chk("pe_pop.rd_ptr", 32'(mif.rd_ptr), 32'd0);
    chk("pe_pop.count", 32'(count), 32'd0);
    sb_add(8'h5A);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 8'h00);

    chk("sb.leftover", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
